decode_stage: RTL and testbench

//   Decode/operand-fetch stage feeding the 16-bit execute ALU. Accepts 32-bit

---
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: reads the register file, forwards the execute result,
// stalls one cycle on back-to-back dependencies and writes results back two cycles later.
module decode_stage #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [DW-1:0] ans_ex,
    input  logic [1:0]    flag_ex,
    output logic [5:0]    op_dec,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [15:0]   pc,
    output logic [1:0]    status_flags
);

    localparam logic [5:0] OP_BUBBLE = 6'b000011;

    logic [5:0]    op;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [2:0]    rt;
    logic [DW-1:0] imm;
    logic          unused_instr_bit;

    assign op               = instr[31:26];
    assign rd               = instr[25:23];
    assign rs               = instr[22:20];
    assign rt               = instr[19:17];
    assign imm              = DW'(instr[15:0]);
    assign unused_instr_bit = instr[16];

    logic [DW-1:0] rf [NREG];

    logic       ex_we;
    logic [2:0] ex_rd;
    logic       wb_we;
    logic [2:0] wb_rd;

    logic          use_imm;
    logic          op_writes;
    logic          issue_we;
    logic          stall;
    logic          issue;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    assign use_imm = (op[5:3] == 3'b001);

    always_comb begin
        case (op) inside
            6'b000000, 6'b000001, 6'b000010,
            [6'b000100:6'b000111],
            [6'b001000:6'b001010],
            [6'b001100:6'b001111],
            6'b010110,
            [6'b011001:6'b011011]: op_writes = 1'b1;
            default:               op_writes = 1'b0;
        endcase
    end

    // rd == 0 is treated as a non-writer so it never causes a hazard or a writeback.
    assign issue_we = op_writes && (rd != 3'd0);

    // Operand read: the value sitting on ans_ex is newer than the register file.
    always_comb begin
        rs_val = rf[rs];
        if (wb_we && (wb_rd == rs)) begin
            rs_val = ans_ex;
        end
        if (rs == 3'd0) begin
            rs_val = '0;
        end
    end

    always_comb begin
        rt_val = rf[rt];
        if (wb_we && (wb_rd == rt)) begin
            rt_val = ans_ex;
        end
        if (rt == 3'd0) begin
            rt_val = '0;
        end
    end

    assign stall = instr_valid && ex_we && (ex_rd != 3'd0) &&
                   ((ex_rd == rs) || (!use_imm && (ex_rd == rt)));
    assign instr_ready = !stall;
    assign issue       = instr_valid && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            op_dec       <= OP_BUBBLE;
            A            <= '0;
            B            <= '0;
            pc           <= '0;
            ex_we        <= 1'b0;
            ex_rd        <= 3'd0;
            wb_we        <= 1'b0;
            wb_rd        <= 3'd0;
            status_flags <= 2'b00;
        end else begin
            wb_we <= ex_we;
            wb_rd <= ex_rd;
            if (issue) begin
                op_dec <= op;
                A      <= rs_val;
                B      <= use_imm ? imm : rt_val;
                pc     <= pc + 16'd1;
                ex_we  <= issue_we;
                ex_rd  <= rd;
            end else begin
                op_dec <= OP_BUBBLE;
                ex_we  <= 1'b0;
            end
            if (wb_we && (wb_rd != 3'd0)) begin
                rf[wb_rd]    <= ans_ex;
                status_flags <= flag_ex;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: an architectural model (instructions applied in
// order to a plain register array) predicts operands, stalls, pc and flags.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] ans_ex;
    logic [1:0]  flag_ex;
    logic [5:0]  op_dec;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] pc;
    logic [1:0]  status_flags;

    always #5 clk = ~clk;

    decode_stage #(.NREG(8), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .ans_ex       (ans_ex),
        .flag_ex      (flag_ex),
        .op_dec       (op_dec),
        .A            (A),
        .B            (B),
        .pc           (pc),
        .status_flags (status_flags)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exec_fn(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            6'b000001: return a - b;
            6'b000010: return a & b;
            6'b000100: return a | b;
            6'b000101: return a ^ b;
            default:   return a + b;
        endcase
    endfunction

    function automatic logic [1:0] flag_fn(input logic [15:0] v);
        return {v == 16'd0, v[15]};
    endfunction

    function automatic bit m_writes(input logic [5:0] op);
        return op inside {6'd0, 6'd1, 6'd2, [6'd4:6'd7], [6'd8:6'd10], [6'd12:6'd15],
                          6'd22, [6'd25:6'd27]};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [15:0] imm);
        return {op, rd, rs, rt, 1'b0, imm};
    endfunction

    // Execute stage stand-in: registers a result computed from the issued operands.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ans_ex  <= 16'd0;
            flag_ex <= 2'b00;
        end else begin
            ans_ex  <= exec_fn(op_dec, A, B);
            flag_ex <= flag_fn(exec_fn(op_dec, A, B));
        end
    end

    // Architectural model state
    logic [15:0] m_rf [8];
    logic [15:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0]  m_flags;
    bit          m_prev_wr;
    logic [2:0]  m_prev_rd;
    logic        last_ready;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
        m_pc      = 16'd0;
        m_a       = 16'd0;
        m_b       = 16'd0;
        m_flags   = 2'b00;
        m_prev_wr = 1'b0;
        m_prev_rd = 3'd0;
    endtask

    // One clock: present (valid, word), check ready, then check the registered outputs.
    task automatic step(input logic valid, input logic [31:0] word, output bit issued);
        logic [5:0]  op;
        logic [2:0]  rd, rs, rt;
        logic [15:0] imm, ea, eb, res;
        bit          imm_sel, stall_m, wr;
        op = word[31:26]; rd = word[25:23]; rs = word[22:20]; rt = word[19:17];
        imm = word[15:0];
        imm_sel = (op[5:3] == 3'b001);
        // A dependency only matters if the writer issued on the immediately preceding edge.
        stall_m = valid && m_prev_wr && (m_prev_rd == rs || (!imm_sel && m_prev_rd == rt));
        @(negedge clk);
        instr_valid = valid;
        instr       = word;
        #1;
        last_ready = instr_ready;
        check_eq("instr_ready", instr_ready, !stall_m);
        @(posedge clk);
        #1;
        issued = valid && !stall_m;
        if (issued) begin
            ea  = (rs == 3'd0) ? 16'd0 : m_rf[rs];
            eb  = imm_sel ? imm : ((rt == 3'd0) ? 16'd0 : m_rf[rt]);
            res = exec_fn(op, ea, eb);
            wr  = m_writes(op) && (rd != 3'd0);
            if (wr) begin
                m_rf[rd] = res;
                m_flags  = flag_fn(res);
            end
            m_pc      = m_pc + 16'd1;
            m_prev_wr = wr;
            m_prev_rd = rd;
            m_a       = ea;
            m_b       = eb;
            check_eq("op_dec_issue", op_dec, op);
        end else begin
            m_prev_wr = 1'b0;
            check_eq("op_dec_bubble", op_dec, 6'b000011);
        end
        check_eq("A", A, m_a);
        check_eq("B", B, m_b);
        check_eq("pc", pc, m_pc);
    endtask

    task automatic issue(input logic [31:0] word);
        bit iss = 1'b0;
        for (int k = 0; k < 4 && !iss; k++) step(1'b1, word, iss);
        if (!iss) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got stalled expected issue");
        end
    endtask

    task automatic idle(input int n);
        bit iss;
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, iss);
    endtask

    task automatic drain_check();
        idle(2);
        check_eq("status_flags", status_flags, m_flags);
    endtask

    task automatic read_all();
        for (int r = 1; r < 8; r++) issue(mk(6'b000011, 3'd0, 3'(r), 3'(r), 16'd0));
    endtask

    logic [5:0] wr_ops [20];
    bit         iss;

    initial begin
        wr_ops = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                   6'd12, 6'd13, 6'd14, 6'd15, 6'd22, 6'd25, 6'd26, 6'd27, 6'd0, 6'd1};
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_op_dec", op_dec, 6'b000011);
        check_eq("rst_pc", pc, 16'd0);
        check_eq("rst_A", A, 16'd0);
        check_eq("rst_B", B, 16'd0);
        check_eq("rst_status", status_flags, 2'b00);
        check_eq("rst_ready", instr_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Random stream with a small register space to provoke hazards and forwarding.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  rop;
            logic [31:0] w;
            rop = ($urandom_range(0, 1) != 0) ? wr_ops[$urandom_range(0, 19)]
                                              : 6'($urandom_range(0, 63));
            w = {rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom)};
            step($urandom_range(0, 9) != 0, w, iss);
            if (n % 500 == 499) drain_check();
        end
        read_all();
        drain_check();

        // Immediate operand and writeback
        issue(mk(6'b001010, 3'd1, 3'd0, 3'd0, 16'h1234));
        check_eq("imm_B", B, 16'h1234);
        idle(2);
        issue(mk(6'b000011, 3'd0, 3'd1, 3'd0, 16'd0));
        check_eq("imm_R1", A, 16'h1234);

        // Distance-1 hazard: one bubble, then forwarded operands
        issue(mk(6'b001010, 3'd1, 3'd0, 3'd0, 16'd5));
        step(1'b1, mk(6'b000000, 3'd2, 3'd1, 3'd1, 16'd0), iss);
        check_eq("d1_ready_low", last_ready, 1'b0);
        check_eq("d1_bubble", op_dec, 6'b000011);
        step(1'b1, mk(6'b000000, 3'd2, 3'd1, 3'd1, 16'd0), iss);
        check_eq("d1_A", A, 16'd5);
        check_eq("d1_B", B, 16'd5);
        idle(2);
        issue(mk(6'b000011, 3'd0, 3'd2, 3'd0, 16'd0));
        check_eq("d1_R2", A, 16'd10);

        // Distance-2 forward: no stall
        issue(mk(6'b001010, 3'd3, 3'd0, 3'd0, 16'd7));
        issue(mk(6'b000011, 3'd0, 3'd0, 3'd0, 16'd0));
        issue(mk(6'b000100, 3'd4, 3'd3, 3'd0, 16'd0));
        check_eq("d2_ready", last_ready, 1'b1);
        check_eq("d2_A", A, 16'd7);

        // R0 protection
        issue(mk(6'b001010, 3'd0, 3'd0, 3'd0, 16'd9));
        issue(mk(6'b000010, 3'd5, 3'd0, 3'd0, 16'd0));
        check_eq("r0_ready", last_ready, 1'b1);
        check_eq("r0_A", A, 16'd0);
        check_eq("r0_B", B, 16'd0);
        drain_check();

        // Reset mid-stream with writes in flight
        issue(mk(6'b001010, 3'd6, 3'd0, 3'd0, 16'h0055));
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = mk(6'b001010, 3'd7, 3'd0, 3'd0, 16'h00AA);
        reset       = 1'b1;
        #1;
        check_eq("mid_rst_op_dec", op_dec, 6'b000011);
        check_eq("mid_rst_pc", pc, 16'd0);
        check_eq("mid_rst_status", status_flags, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        model_reset();
        read_all();
        check_eq("mid_rst_R7", A, 16'd0);
        drain_check();

        // pc wrap, and a stall at pc=FFFF holds pc
        for (int k = 0; k < 70000 && m_pc != 16'hFFFE; k++) begin
            issue(mk(6'b000011, 3'd0, 3'd0, 3'd0, 16'd0));
        end
        issue(mk(6'b001010, 3'd1, 3'd0, 3'd0, 16'd1));
        check_eq("wrap_pc_ffff", pc, 16'hFFFF);
        step(1'b1, mk(6'b000000, 3'd2, 3'd1, 3'd1, 16'd0), iss);
        check_eq("wrap_stall_pc", pc, 16'hFFFF);
        step(1'b1, mk(6'b000000, 3'd2, 3'd1, 3'd1, 16'd0), iss);
        check_eq("wrap_pc_0", pc, 16'd0);
        read_all();
        drain_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
